// File: rtl/ram_dual_rmw_pkg.sv
// Shared types and byte-lane helpers for the dual-port RMW RAM wrapper.
// The helpers work on 64-bit containers so that 32- and 64-bit instances share them.
package ram_dual_rmw_pkg;

    localparam int MAX_W  = 64;
    localparam int MAX_BE = MAX_W / 8;

    localparam string FRAC_YES = "YES";
    localparam string FRAC_NO  = "NO";

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WB   = 1'b1
    } rmw_state_e;

    function automatic bit dat_width_ok(input int w);
        return (w == 32) || (w == 64);
    endfunction

    // Lane k of data lands in lane k+ofs; lanes pushed past be_w are dropped, never wrapped.
    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0]  base,
        input logic [MAX_W-1:0]  data,
        input logic [MAX_BE-1:0] be,
        input logic [2:0]        ofs,
        input int                be_w
    );
        logic [MAX_W-1:0] res;
        int               dst;
        res = base;
        for (int k = 0; k < MAX_BE; k++) begin
            dst = k + int'(ofs);
            if (be[k] && (dst < be_w)) begin
                res[dst*8 +: 8] = data[k*8 +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [MAX_W-1:0] lane_shift(
        input logic [MAX_W-1:0] word,
        input logic [2:0]       ofs
    );
        return word >> {ofs, 3'b000};
    endfunction

endpackage

// File: rtl/ram_dual.sv
// True dual-port synchronous RAM, read-first, one registered read per port.
// Both writes live in one process; the wrapper guarantees they never target the same word.
module ram_dual #(
    parameter int    dat_width = 32,
    parameter int    mem_size  = 1024,
    parameter int    adr_w     = 10,
    parameter string mem_init  = "YES",
    parameter string mem_type  = "hex",
    parameter string mem_data  = "data.hex"
) (
    input  logic                 clk_i,
    input  logic [adr_w-1:0]     a_addr_i,
    input  logic                 a_we_i,
    input  logic [dat_width-1:0] a_wdata_i,
    output logic [dat_width-1:0] a_rdata_o,
    input  logic [adr_w-1:0]     b_addr_i,
    input  logic                 b_we_i,
    input  logic [dat_width-1:0] b_wdata_i,
    output logic [dat_width-1:0] b_rdata_o
);

    logic [dat_width-1:0] mem_q [mem_size];
    logic [dat_width-1:0] a_rdata_q;
    logic [dat_width-1:0] b_rdata_q;

    // Preload content is supplied by the memory-init flow; only the settings are validated here.
    if (!(mem_init == "YES" || mem_init == "NO")) begin : g_bad_init
        $error("ram_dual: mem_init must be YES or NO");
    end
    if (!(mem_type == "hex" || mem_type == "bin")) begin : g_bad_type
        $error("ram_dual: mem_type must be hex or bin");
    end
    if (mem_init == "YES" && mem_data == "") begin : g_bad_file
        $error("ram_dual: mem_data must name a file when mem_init is YES");
    end

    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
        a_rdata_q <= mem_q[a_addr_i];
        b_rdata_q <= mem_q[b_addr_i];
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/ram_dual_rmw_port.sv
// One bus port: IDLE/WB FSM, request buffers, byte-lane merge and read alignment.
// fwd_* tells the port that another write hits its word this cycle; it replaces the RAM data next cycle.
module ram_rmw_port import ram_dual_rmw_pkg::*; #(
    parameter int    dat_width = 32,
    parameter int    adr_width = 32,
    parameter int    mem_aw    = 10,
    parameter string FRAC      = "NO"
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [adr_width-1:0]   addr_bi,
    input  logic [dat_width/8-1:0] be_bi,
    input  logic [dat_width-1:0]   wdata_bi,
    output logic                   ack_o,
    output logic                   resp_o,
    output logic [dat_width-1:0]   rdata_bo,
    output logic [mem_aw-1:0]      mem_addr_o,
    output logic                   mem_we_o,
    output logic [dat_width-1:0]   mem_wdata_o,
    input  logic [dat_width-1:0]   mem_rdata_i,
    input  logic                   fwd_vld_i,
    input  logic [dat_width-1:0]   fwd_data_i
);

    localparam int BE_W    = dat_width / 8;
    localparam int OFS_W   = $clog2(BE_W);
    localparam bit FRAC_EN = (FRAC == FRAC_YES);

    rmw_state_e           state_q, state_d;
    logic                 resp_q, resp_d;
    logic                 fwd_vld_q, fwd_vld_d;
    logic [dat_width-1:0] fwd_data_q, fwd_data_d;
    logic [mem_aw-1:0]    adr_q, adr_d;
    logic [OFS_W-1:0]     ofs_q, ofs_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic [dat_width-1:0] wdata_q, wdata_d;

    logic [mem_aw-1:0]    req_word;
    logic [OFS_W-1:0]     req_ofs;
    logic                 full_wr;
    logic                 part_wr;
    logic [dat_width-1:0] base;
    logic [dat_width-1:0] merged;
    logic                 unused_addr_bits;

    assign req_word = addr_bi[OFS_W +: mem_aw];
    assign req_ofs  = FRAC_EN ? addr_bi[OFS_W-1:0] : '0;
    assign full_wr  = !FRAC_EN || ((be_bi == '1) && (req_ofs == '0));
    assign part_wr  = req_i && we_i && !full_wr;
    assign unused_addr_bits = ^{addr_bi, be_bi};

    // A write landing on our word in the read cycle beats the stale RAM output.
    assign base     = fwd_vld_q ? fwd_data_q : mem_rdata_i;
    assign merged   = dat_width'(lane_merge(64'(base), 64'(wdata_q), 8'(be_q), 3'(ofs_q), BE_W));
    assign rdata_bo = dat_width'(lane_shift(64'(base), 3'(ofs_q)));
    assign resp_o   = resp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (part_wr) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_o       = 1'b0;
        mem_addr_o  = req_word;
        mem_we_o    = 1'b0;
        mem_wdata_o = wdata_bi;
        case (state_q)
            ST_IDLE: begin
                ack_o    = req_i;
                mem_we_o = req_i && we_i && full_wr;
            end
            ST_WB: begin
                mem_addr_o  = adr_q;
                mem_we_o    = !rst_i;
                mem_wdata_o = merged;
            end
            default: ;
        endcase
    end

    always_comb begin
        adr_d      = adr_q;
        ofs_d      = ofs_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        resp_d     = 1'b0;
        fwd_vld_d  = fwd_vld_i;
        fwd_data_d = fwd_data_i;
        if ((state_q == ST_IDLE) && req_i) begin
            adr_d   = req_word;
            ofs_d   = req_ofs;
            be_d    = be_bi;
            wdata_d = wdata_bi;
            resp_d  = !we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q    <= 1'b0;
            fwd_vld_q <= 1'b0;
        end else begin
            resp_q    <= resp_d;
            fwd_vld_q <= fwd_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        adr_q      <= adr_d;
        ofs_q      <= ofs_d;
        be_q       <= be_d;
        wdata_q    <= wdata_d;
        fwd_data_q <= fwd_data_d;
    end

endmodule

// File: rtl/ram_dual_rmw.sv
// Dual-port RAM wrapper with per-port read-modify-write, write-first bypass and
// cross-port collision handling; port 0 wins whenever both ports write one word.
module ram_dual_rmw import ram_dual_rmw_pkg::*; #(
    parameter string mem_init  = "YES",
    parameter string mem_type  = "hex",
    parameter string mem_data  = "data.hex",
    parameter int    dat_width = 32,
    parameter int    adr_width = 32,
    parameter int    mem_size  = 1024,
    parameter string P0_FRAC   = "NO",
    parameter string P1_FRAC   = "NO"
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   bus0_req_i,
    input  logic                   bus0_we_i,
    input  logic [adr_width-1:0]   bus0_addr_bi,
    input  logic [dat_width/8-1:0] bus0_be_bi,
    input  logic [dat_width-1:0]   bus0_wdata_bi,
    output logic                   bus0_ack_o,
    output logic                   bus0_resp_o,
    output logic [dat_width-1:0]   bus0_rdata_bo,
    input  logic                   bus1_req_i,
    input  logic                   bus1_we_i,
    input  logic [adr_width-1:0]   bus1_addr_bi,
    input  logic [dat_width/8-1:0] bus1_be_bi,
    input  logic [dat_width-1:0]   bus1_wdata_bi,
    output logic                   bus1_ack_o,
    output logic                   bus1_resp_o,
    output logic [dat_width-1:0]   bus1_rdata_bo,
    output logic                   coll_o
);

    localparam int MEM_AW = $clog2(mem_size);

    if (!dat_width_ok(dat_width)) begin : g_bad_width
        $error("ram_dual_rmw: dat_width must be 32 or 64");
    end

    logic [MEM_AW-1:0]    m0_addr, m1_addr;
    logic                 m0_we, m1_we;
    logic [dat_width-1:0] m0_wdata, m1_wdata;
    logic [dat_width-1:0] m0_rdata, m1_rdata;
    logic                 fwd0_vld, fwd1_vld;
    logic                 coll_q, coll_d;

    // A reading port never writes in the same cycle, so only the other port can hit its word.
    assign fwd0_vld = m1_we && (m1_addr == m0_addr);
    assign fwd1_vld = m0_we && (m0_addr == m1_addr);

    always_comb begin
        coll_d = m0_we && m1_we && (m0_addr == m1_addr);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign coll_o = coll_q;

    ram_rmw_port #(
        .dat_width (dat_width),
        .adr_width (adr_width),
        .mem_aw    (MEM_AW),
        .FRAC      (P0_FRAC)
    ) u_port0 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (bus0_req_i),
        .we_i        (bus0_we_i),
        .addr_bi     (bus0_addr_bi),
        .be_bi       (bus0_be_bi),
        .wdata_bi    (bus0_wdata_bi),
        .ack_o       (bus0_ack_o),
        .resp_o      (bus0_resp_o),
        .rdata_bo    (bus0_rdata_bo),
        .mem_addr_o  (m0_addr),
        .mem_we_o    (m0_we),
        .mem_wdata_o (m0_wdata),
        .mem_rdata_i (m0_rdata),
        .fwd_vld_i   (fwd0_vld),
        .fwd_data_i  (m1_wdata)
    );

    ram_rmw_port #(
        .dat_width (dat_width),
        .adr_width (adr_width),
        .mem_aw    (MEM_AW),
        .FRAC      (P1_FRAC)
    ) u_port1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (bus1_req_i),
        .we_i        (bus1_we_i),
        .addr_bi     (bus1_addr_bi),
        .be_bi       (bus1_be_bi),
        .wdata_bi    (bus1_wdata_bi),
        .ack_o       (bus1_ack_o),
        .resp_o      (bus1_resp_o),
        .rdata_bo    (bus1_rdata_bo),
        .mem_addr_o  (m1_addr),
        .mem_we_o    (m1_we),
        .mem_wdata_o (m1_wdata),
        .mem_rdata_i (m1_rdata),
        .fwd_vld_i   (fwd1_vld),
        .fwd_data_i  (m0_wdata)
    );

    ram_dual #(
        .dat_width (dat_width),
        .mem_size  (mem_size),
        .adr_w     (MEM_AW),
        .mem_init  (mem_init),
        .mem_type  (mem_type),
        .mem_data  (mem_data)
    ) u_ram (
        .clk_i     (clk_i),
        .a_addr_i  (m0_addr),
        .a_we_i    (m0_we),
        .a_wdata_i (m0_wdata),
        .a_rdata_o (m0_rdata),
        .b_addr_i  (m1_addr),
        .b_we_i    (m1_we && !coll_d),
        .b_wdata_i (m1_wdata),
        .b_rdata_o (m1_rdata)
    );

endmodule

// File: tb/tb_ram_dual_rmw.sv
// Directed bench: a 32-bit instance (port 0 fractional) and a 64-bit instance (port 1 fractional).
module tb_ram_dual_rmw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a0_req, a0_we, a0_ack, a0_resp;
    logic [31:0] a0_addr, a0_wdata, a0_rdata;
    logic [3:0]  a0_be;
    logic        a1_req, a1_we, a1_ack, a1_resp;
    logic [31:0] a1_addr, a1_wdata, a1_rdata;
    logic [3:0]  a1_be;
    logic        a_coll;

    logic        b0_req, b0_we, b0_ack, b0_resp;
    logic [31:0] b0_addr;
    logic [63:0] b0_wdata, b0_rdata;
    logic [7:0]  b0_be;
    logic        b1_req, b1_we, b1_ack, b1_resp;
    logic [31:0] b1_addr;
    logic [63:0] b1_wdata, b1_rdata;
    logic [7:0]  b1_be;
    logic        b_coll;

    int n_vec  = 0;
    int n_miss = 0;

    ram_dual_rmw #(
        .mem_init ("NO"), .mem_type ("hex"), .mem_data ("data.hex"),
        .dat_width (32), .adr_width (32), .mem_size (1024),
        .P0_FRAC ("YES"), .P1_FRAC ("NO")
    ) u_dut_a (
        .clk_i (clk), .rst_i (rst),
        .bus0_req_i (a0_req), .bus0_we_i (a0_we), .bus0_addr_bi (a0_addr),
        .bus0_be_bi (a0_be), .bus0_wdata_bi (a0_wdata), .bus0_ack_o (a0_ack),
        .bus0_resp_o (a0_resp), .bus0_rdata_bo (a0_rdata),
        .bus1_req_i (a1_req), .bus1_we_i (a1_we), .bus1_addr_bi (a1_addr),
        .bus1_be_bi (a1_be), .bus1_wdata_bi (a1_wdata), .bus1_ack_o (a1_ack),
        .bus1_resp_o (a1_resp), .bus1_rdata_bo (a1_rdata),
        .coll_o (a_coll)
    );

    ram_dual_rmw #(
        .mem_init ("NO"), .mem_type ("hex"), .mem_data ("data.hex"),
        .dat_width (64), .adr_width (32), .mem_size (1024),
        .P0_FRAC ("NO"), .P1_FRAC ("YES")
    ) u_dut_b (
        .clk_i (clk), .rst_i (rst),
        .bus0_req_i (b0_req), .bus0_we_i (b0_we), .bus0_addr_bi (b0_addr),
        .bus0_be_bi (b0_be), .bus0_wdata_bi (b0_wdata), .bus0_ack_o (b0_ack),
        .bus0_resp_o (b0_resp), .bus0_rdata_bo (b0_rdata),
        .bus1_req_i (b1_req), .bus1_we_i (b1_we), .bus1_addr_bi (b1_addr),
        .bus1_be_bi (b1_be), .bus1_wdata_bi (b1_wdata), .bus1_ack_o (b1_ack),
        .bus1_resp_o (b1_resp), .bus1_rdata_bo (b1_rdata),
        .coll_o (b_coll)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a0_drv(input logic r, input logic w, input logic [31:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
        a0_req = r; a0_we = w; a0_addr = ad; a0_be = be; a0_wdata = wd;
    endtask

    task automatic a1_drv(input logic r, input logic w, input logic [31:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
        a1_req = r; a1_we = w; a1_addr = ad; a1_be = be; a1_wdata = wd;
    endtask

    task automatic b0_drv(input logic r, input logic w, input logic [31:0] ad,
                          input logic [7:0] be, input logic [63:0] wd);
        b0_req = r; b0_we = w; b0_addr = ad; b0_be = be; b0_wdata = wd;
    endtask

    task automatic b1_drv(input logic r, input logic w, input logic [31:0] ad,
                          input logic [7:0] be, input logic [63:0] wd);
        b1_req = r; b1_we = w; b1_addr = ad; b1_be = be; b1_wdata = wd;
    endtask

    initial begin
        rst = 1'b1;
        a0_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        a1_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        b0_drv(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        b1_drv(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        step();
        step();
        chk("rst_a0_resp", 64'(a0_resp), 64'h0);
        chk("rst_a1_resp", 64'(a1_resp), 64'h0);
        chk("rst_a_coll",  64'(a_coll),  64'h0);
        chk("rst_b0_resp", 64'(b0_resp), 64'h0);
        chk("rst_b1_resp", 64'(b1_resp), 64'h0);
        chk("rst_b_coll",  64'(b_coll),  64'h0);
        rst = 1'b0;

        // full write then read back
        a0_drv(1'b1, 1'b1, 32'h10, 4'hF, 32'hAABBCCDD);
        #1 chk("fw_ack", 64'(a0_ack), 64'h1);
        step();
        chk("fw_noresp", 64'(a0_resp), 64'h0);
        a0_drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1 chk("rd10_ack", 64'(a0_ack), 64'h1);
        step();
        chk("rd10_resp", 64'(a0_resp), 64'h1);
        chk("rd10_data", 64'(a0_rdata), 64'hAABBCCDD);

        // partial write, read requested during WB
        a0_drv(1'b1, 1'b1, 32'h11, 4'h1, 32'h000000EE);
        #1 chk("pw_ack", 64'(a0_ack), 64'h1);
        step();
        a0_drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1 chk("wb_ack_low", 64'(a0_ack), 64'h0);
        step();
        chk("wb_noresp", 64'(a0_resp), 64'h0);
        #1 chk("post_wb_ack", 64'(a0_ack), 64'h1);
        step();
        chk("pw_rd_resp", 64'(a0_resp), 64'h1);
        chk("pw_rd_data", 64'(a0_rdata), 64'hAABBEEDD);
        a0_drv(1'b1, 1'b0, 32'h12, 4'h0, 32'h0);
        step();
        chk("rd12_data", 64'(a0_rdata), 64'h0000AABB);

        // unaligned overflow: only lane 0 fits at offset 3
        a0_drv(1'b1, 1'b1, 32'h14, 4'hF, 32'h55667788);
        step();
        a0_drv(1'b1, 1'b1, 32'h13, 4'hF, 32'h11223344);
        step();
        a0_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        a0_drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        a1_drv(1'b1, 1'b0, 32'h16, 4'h0, 32'h0);
        step();
        chk("ovf_w10", 64'(a0_rdata), 64'h44BBEEDD);
        chk("ovf_p1_resp", 64'(a1_resp), 64'h1);
        chk("ovf_w14", 64'(a1_rdata), 64'h55667788);

        // same-word writes on both ports
        a0_drv(1'b1, 1'b1, 32'h20, 4'hF, 32'h00000001);
        a1_drv(1'b1, 1'b1, 32'h20, 4'hF, 32'h00000002);
        #1 chk("coll_ack0", 64'(a0_ack), 64'h1);
        chk("coll_ack1", 64'(a1_ack), 64'h1);
        step();
        chk("coll_pulse", 64'(a_coll), 64'h1);
        a0_drv(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        a1_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("coll_once", 64'(a_coll), 64'h0);
        chk("coll_mem", 64'(a0_rdata), 64'h00000001);

        // write-first bypass to the other port
        a0_drv(1'b1, 1'b1, 32'h20, 4'hF, 32'h00000009);
        a1_drv(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        step();
        chk("byp_resp", 64'(a1_resp), 64'h1);
        chk("byp_data", 64'(a1_rdata), 64'h00000009);
        chk("byp_nocoll", 64'(a_coll), 64'h0);

        // bypass of a WB-phase merged write
        a0_drv(1'b1, 1'b1, 32'h10, 4'h2, 32'h00007700);
        a1_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        a0_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        a1_drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        step();
        chk("wbbyp_data", 64'(a1_rdata), 64'h44BB77DD);
        a1_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // reset during WB
        a0_drv(1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
        step();
        a0_drv(1'b1, 1'b1, 32'h31, 4'h1, 32'h000000AA);
        step();
        rst = 1'b1;
        a0_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        a1_drv(1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
        step();
        rst = 1'b0;
        chk("rstwb_resp0", 64'(a0_resp), 64'h0);
        chk("rstwb_resp1", 64'(a1_resp), 64'h0);
        a1_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        a0_drv(1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
        #1 chk("rstwb_idle_ack", 64'(a0_ack), 64'h1);
        step();
        chk("rstwb_word", 64'(a0_rdata), 64'hCAFEF00D);
        a0_drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // 64-bit: port 1 RMW snoops a port 0 full write to the same word
        b0_drv(1'b1, 1'b1, 32'h08, 8'hFF, 64'h0);
        step();
        b0_drv(1'b1, 1'b1, 32'h08, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
        b1_drv(1'b1, 1'b1, 32'h08, 8'h0F, 64'h00000000_12345678);
        #1 chk("b_ack0", 64'(b0_ack), 64'h1);
        chk("b_ack1", 64'(b1_ack), 64'h1);
        step();
        chk("b_nocoll", 64'(b_coll), 64'h0);
        b0_drv(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        b1_drv(1'b1, 1'b0, 32'h08, 8'h0, 64'h0);
        #1 chk("b_wb_ack_low", 64'(b1_ack), 64'h0);
        step();
        b1_drv(1'b1, 1'b0, 32'h0C, 8'h0, 64'h0);
        #1 chk("b_rd_ack", 64'(b1_ack), 64'h1);
        step();
        chk("b_rd_resp", 64'(b1_resp), 64'h1);
        chk("b_rd0c", b1_rdata, 64'h00000000_FFFFFFFF);
        b1_drv(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        b0_drv(1'b1, 1'b0, 32'h08, 8'h0, 64'h0);
        step();
        chk("b_merge", b0_rdata, 64'hFFFFFFFF_12345678);
        b0_drv(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ram_dual_rmw.md
Name: ram_dual_rmw

Overview:
Parametrised dual-port synchronous RAM wrapper with per-port read-modify-write for partial and unaligned writes. It generalises data width to 32 or 64 bits, with byte-lane count derived from the width. It adds write-first read bypass and cross-port hazard handling on top of the existing ram_dual storage primitive. It sits between core instruction/data buses and on-chip memory.

Parameters:
mem_init, "YES", preload memory from file
mem_type, "hex", init file format ("hex"/"bin")
mem_data, "data.hex", init file name
dat_width, 32, data word width; 32 or 64 only
adr_width, 32, byte address width on the bus
mem_size, 1024, depth in words
P0_FRAC, "NO", "YES" enables RMW and unaligned access on port 0
P1_FRAC, "NO", same for port 1
(derived) BE_W = dat_width/8; OFS_W = log2(BE_W)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
busN_req_i  in  1  request, port N (N = 0, 1)
busN_we_i  in  1  1 = write, 0 = read
busN_addr_bi  in  adr_width  byte address
busN_be_bi  in  BE_W  byte enables, lane 0 = LSB, relative to the address offset
busN_wdata_bi  in  dat_width  write data, lane-aligned to offset 0
busN_ack_o  out  1  request accepted this cycle (combinational)
busN_resp_o  out  1  read data valid, one cycle after read ack
busN_rdata_bo  out  dat_width  read data
coll_o  out  1  one-cycle pulse: both ports wrote the same word in the same cycle

Behaviour:
- Word index = addr[adr_width-1:OFS_W]; offset = addr[OFS_W-1:0]. With FRAC = "NO", the offset is ignored.
- Per-port FSM, states IDLE and WB. Reset puts both ports in IDLE with resp_o = 0 and coll_o = 0. rdata_bo is don't-care while resp_o = 0.
- Read: ack_o = req_i in IDLE. resp_o = 1 exactly one cycle later.
  - rdata_bo = memory word >> (offset*8) when FRAC = "YES"; the offset is taken from the registered address. Vacated upper lanes read as 0.
- Full write: we = 1, FRAC = "NO", or be = all ones with offset 0.
  - Acked and written in the same cycle, stays in IDLE, no resp.
- Partial write (FRAC = "YES", and be ≠ all ones or offset ≠ 0):
  - Cycle N: ack = 1, memory read of the target word; addr, be and wdata are buffered; FSM goes to WB.
  - Cycle N+1 (WB): ack_o = 0. The merged word is written; lane k+offset takes wdata lane k where be[k] = 1, for k+offset < BE_W. Lanes past the word end are dropped with no wrap into the next word. FSM returns to IDLE.
  - Sustained throughput: one partial write per 2 cycles.
- Read bypass (write-first): if a port's read targets a word being written this cycle by either port, its resp data is that write's data.
  - When both ports write that word in that cycle, the port-0 data is returned.
  - Bypass covers WB-phase merged writes as well as full writes.
- RMW snoop: if, during a port's read phase (cycle N), the other port writes the same word, the merge base is the other port's write data, not the stale memory word.
- Same-cycle same-word writes by both ports: port 0 data is stored, both ports are acked, coll_o = 1 for one cycle.
- Reset mid-operation: rst_i in the WB cycle suppresses the memory write. FSM goes to IDLE and any pending resp is cleared on the next edge.
- req_i deasserted during WB has no effect; the buffered write still completes.

Decomposition:
- Shared package: byte-lane merge function (base, data, be, offset) → word; lane-shift function for read alignment; FRAC string constants; dat_width legality check (32/64).
- Sub-module ram_rmw_port: one per port. Holds the FSM, buffers, merge, read alignment and resp generation. The top level instantiates two of them plus ram_dual, and holds the bypass, snoop and collision logic.

Test Plan:
- dat_width = 32, P0_FRAC = "YES". Write 0xAABBCCDD to addr 0x10 with be = 0xF, then read 0x10 → resp next cycle, rdata 0xAABBCCDD, ack never drops.
- Same setup: write wdata 0x000000EE, be = 0x1 to addr 0x11, then read 0x10 → ack low in the WB cycle, rdata 0xAABBEEDD. Read 0x12 → 0x0000AABB.
- Unaligned overflow: be = 0xF at addr 0x13 with wdata 0x11223344 → word 0x10 = 0x44BBEEDD, word 0x14 unchanged.
- Both ports write addr 0x20 in the same cycle (0x1, 0x2) → memory holds 0x1, coll_o pulses once. Port 1 reading 0x20 in that cycle gets 0x1.
- dat_width = 64, P1_FRAC = "YES". Port 1 partial write be = 0x0F at 0x08 while port 0 full-writes 0xFFFFFFFF_FFFFFFFF to 0x08 in the same cycle → merged result upper 0xFFFFFFFF, lower = port 1 data.
- Assert rst_i during WB → the targeted word is unchanged, resp_o = 0, FSM in IDLE.
